// File: rtl/ucie_ctl_tx_gen2_pkg.sv
// Shared types and constants for the UCIe controller TX datapath.
// Latency: n/a (types, constants and a parity helper only).
// Backpressure: n/a.
// Contents: tx_state_t FSM encoding, LSTS_ACTIVE link-state code,
//           byte_even_par() helper used when per-byte parity is built in.
package ucie_ctl_pkg;

  // Encodings are visible on o_tx_state for debug, so keep them fixed.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10,
    FLUSH  = 2'b11
  } tx_state_t;

  // FDI pl_state_sts code for the Active link state.
  localparam logic [3:0] LSTS_ACTIVE = 4'b0001;

  // Even parity bit for one byte: set when the byte has an odd number of ones,
  // so that byte plus parity bit always carry an even count.
  function automatic logic byte_even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ucie_ctl_tx_gen2_if.sv
// FDI/RDI handshake bundle plus status outputs of the TX datapath.
// Latency: n/a (wires only).
// Backpressure: o_fdi_pl_trdy toward the adapter, i_rdi_pl_trdy from the PHY.
// Modports: slave = TX block view, master = adapter/PHY (or bench) view.
// Optional: UCIE_CTL_TX_PARITY_EN adds o_rdi_lp_dpar.
interface ucie_ctl_tx_gen2_if #(
  parameter int FIFO_D_SIZE = 64,
  parameter int FIFO_P_SIZE = 3
);

  logic [3:0]             i_fdi_pl_state_sts;
  logic                   i_fdi_lp_valid;
  logic                   i_fdi_lp_irdy;
  logic [FIFO_D_SIZE-1:0] i_fdi_lp_data;
  logic                   o_fdi_pl_trdy;
  logic                   i_rdi_pl_trdy;
  logic                   o_rdi_lp_valid;
  logic                   o_rdi_lp_irdy;
  logic [FIFO_D_SIZE-1:0] o_rdi_lp_data;
  logic                   o_tx_overf_err;
  logic [FIFO_P_SIZE:0]   o_tx_level;
  logic [1:0]             o_tx_state;
`ifdef UCIE_CTL_TX_PARITY_EN
  logic [FIFO_D_SIZE/8-1:0] o_rdi_lp_dpar;
`endif

  modport slave (
    input  i_fdi_pl_state_sts, i_fdi_lp_valid, i_fdi_lp_irdy, i_fdi_lp_data,
    input  i_rdi_pl_trdy,
    output o_fdi_pl_trdy, o_rdi_lp_valid, o_rdi_lp_irdy, o_rdi_lp_data,
`ifdef UCIE_CTL_TX_PARITY_EN
    output o_rdi_lp_dpar,
`endif
    output o_tx_overf_err, o_tx_level, o_tx_state
  );

  modport master (
    output i_fdi_pl_state_sts, i_fdi_lp_valid, i_fdi_lp_irdy, i_fdi_lp_data,
    output i_rdi_pl_trdy,
    input  o_fdi_pl_trdy, o_rdi_lp_valid, o_rdi_lp_irdy, o_rdi_lp_data,
`ifdef UCIE_CTL_TX_PARITY_EN
    input  o_rdi_lp_dpar,
`endif
    input  o_tx_overf_err, o_tx_level, o_tx_state
  );

endinterface

// File: rtl/ucie_ctl_tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit level counter.
// Latency: a pushed word is visible on o_head_data the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle.
// Ports: i_clk, i_rst (sync, active-low), i_push/i_push_data, i_pop, i_flush,
//        o_head_data, o_level (0..depth), o_full, o_empty.
module ucie_ctl_tx_sync_fifo #(
  parameter int WIDTH  = 64,
  parameter int P_SIZE = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [WIDTH-1:0]  o_head_data,
  output logic [P_SIZE:0]   o_level,
  output logic              o_full,
  output logic              o_empty
);

  localparam int DEPTH = 1 << P_SIZE;
  localparam int LVL_W = P_SIZE + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [P_SIZE-1:0] wptr_q;
  logic [P_SIZE-1:0] rptr_q;
  logic [P_SIZE:0]   level_q;
  logic              do_push;
  logic              do_pop;

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign o_empty = (level_q == '0);

  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Pointers are exactly P_SIZE bits wide, so increment wraps modulo depth.
  // Full/empty come from level_q because equal pointers alone are ambiguous.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (i_flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; stale words sit behind the pointers and are never shown
  // as valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr_q] <= i_push_data;
  end

  assign o_head_data = mem[rptr_q];
  assign o_level     = level_q;

endmodule

// File: rtl/ucie_ctl_tx_gen2.sv
// UCIe controller TX datapath: FDI flits buffered in a FWFT FIFO, forwarded to RDI.
// Latency: flit accepted at edge N is offered on RDI from cycle N+1.
// Backpressure: o_fdi_pl_trdy drops at level >= depth-AFULL_MARGIN or outside ACTIVE;
//               RDI side holds the head flit until i_rdi_pl_trdy.
// Ports: i_clk, i_rst (sync, active-low), bus (ucie_ctl_tx_gen2_if.slave).
// Optional: UCIE_CTL_TX_PARITY_EN stores per-byte even parity and drives o_rdi_lp_dpar.
module ucie_ctl_tx_gen2
  import ucie_ctl_pkg::*;
#(
  parameter int FIFO_D_SIZE   = 64,
  parameter int FIFO_P_SIZE   = 3,
  parameter int AFULL_MARGIN  = 2,
  parameter int UCIE_ACTIVE   = 1,
  parameter int DRAIN_ON_EXIT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ucie_ctl_tx_gen2_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_P_SIZE;
  localparam int LVL_W = FIFO_P_SIZE + 1;
`ifdef UCIE_CTL_TX_PARITY_EN
  localparam int PAR_W  = FIFO_D_SIZE / 8;
  localparam int FIFO_W = FIFO_D_SIZE + PAR_W;
`else
  localparam int FIFO_W = FIFO_D_SIZE;
`endif
  localparam logic [LVL_W-1:0] AFULL_THR = LVL_W'(DEPTH - AFULL_MARGIN);

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic              act;
  logic              fdi_trdy;
  logic              rdi_send;
  logic              push;
  logic              pop;
  logic              flush;
  logic              ovf_hit;
  logic              overf_err_q;
  logic [FIFO_W-1:0] push_dat;
  logic [FIFO_W-1:0] head_dat;
  logic [LVL_W-1:0]  level;
  logic              fifo_full;
  logic              fifo_empty;

  assign act = (bus.i_fdi_pl_state_sts == LSTS_ACTIVE) || (UCIE_ACTIVE == 0);

  // Both handshake outputs decode registered state only; nothing from the
  // adapter or PHY inputs reaches them combinationally.
  assign fdi_trdy = (state_q == ACTIVE) && (level < AFULL_THR);
  assign rdi_send = ((state_q == ACTIVE) || (state_q == DRAIN)) && !fifo_empty;

  assign push = bus.i_fdi_lp_valid & bus.i_fdi_lp_irdy & fdi_trdy;
  assign pop  = rdi_send & bus.i_rdi_pl_trdy;

  // A write attempt into a full FIFO while ACTIVE is an adapter protocol error;
  // a pop in the same cycle does not excuse it.
  assign ovf_hit = bus.i_fdi_lp_valid & bus.i_fdi_lp_irdy & (state_q == ACTIVE) & fifo_full;

  // Clear the FIFO on the edge entering FLUSH so level already reads 0 while in
  // FLUSH; FLUSH itself can neither push nor pop.
  assign flush = (state_d == FLUSH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (act) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!act) begin
          if ((DRAIN_ON_EXIT != 0) && !fifo_empty) state_d = DRAIN;
          else                                     state_d = FLUSH;
        end
      end
      DRAIN: begin
        // Returning to Active keeps the remaining flits queued.
        if (act)             state_d = ACTIVE;
        else if (fifo_empty) state_d = IDLE;
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      overf_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ovf_hit) overf_err_q <= 1'b1;
    end
  end

`ifdef UCIE_CTL_TX_PARITY_EN
  logic [PAR_W-1:0] push_par;

  always_comb begin
    push_par = '0;
    for (int b = 0; b < PAR_W; b++) begin
      push_par[b] = byte_even_par(bus.i_fdi_lp_data[8*b +: 8]);
    end
  end

  assign push_dat          = {push_par, bus.i_fdi_lp_data};
  assign bus.o_rdi_lp_data = head_dat[FIFO_D_SIZE-1:0];
  // Gated with valid so the parity lanes read 0 whenever nothing is offered.
  assign bus.o_rdi_lp_dpar = rdi_send ? head_dat[FIFO_W-1:FIFO_D_SIZE] : '0;
`else
  assign push_dat          = bus.i_fdi_lp_data;
  assign bus.o_rdi_lp_data = head_dat;
`endif

  ucie_ctl_tx_sync_fifo #(
    .WIDTH  (FIFO_W),
    .P_SIZE (FIFO_P_SIZE)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_dat),
    .i_pop       (pop),
    .i_flush     (flush),
    .o_head_data (head_dat),
    .o_level     (level),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  assign bus.o_fdi_pl_trdy  = fdi_trdy;
  assign bus.o_rdi_lp_valid = rdi_send;
  assign bus.o_rdi_lp_irdy  = rdi_send;
  assign bus.o_tx_overf_err = overf_err_q;
  assign bus.o_tx_level     = level;
  assign bus.o_tx_state     = state_q;

endmodule

// File: tb/tb_ucie_ctl_tx_gen2.sv
// Bench for ucie_ctl_tx_gen2: three instances (defaults, flush-on-exit, zero margin).
// Latency: n/a.
// Backpressure: n/a.
module tb_ucie_ctl_tx_gen2;

  localparam logic [3:0] A1 = 4'b0001;
  localparam logic [3:0] RT = 4'b1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sts;
  logic        vld;
  logic        irdy;
  logic        rtrdy;
  logic [63:0] dat;

  always #5 clk = ~clk;

  ucie_ctl_tx_gen2_if #(.FIFO_D_SIZE(64), .FIFO_P_SIZE(3)) if_a ();
  ucie_ctl_tx_gen2_if #(.FIFO_D_SIZE(64), .FIFO_P_SIZE(3)) if_f ();
  ucie_ctl_tx_gen2_if #(.FIFO_D_SIZE(64), .FIFO_P_SIZE(3)) if_o ();

  assign if_a.i_fdi_pl_state_sts = sts;
  assign if_a.i_fdi_lp_valid     = vld;
  assign if_a.i_fdi_lp_irdy      = irdy;
  assign if_a.i_fdi_lp_data      = dat;
  assign if_a.i_rdi_pl_trdy      = rtrdy;
  assign if_f.i_fdi_pl_state_sts = sts;
  assign if_f.i_fdi_lp_valid     = vld;
  assign if_f.i_fdi_lp_irdy      = irdy;
  assign if_f.i_fdi_lp_data      = dat;
  assign if_f.i_rdi_pl_trdy      = rtrdy;

  ucie_ctl_tx_gen2 #(.FIFO_D_SIZE(64), .FIFO_P_SIZE(3), .AFULL_MARGIN(2),
                     .UCIE_ACTIVE(1), .DRAIN_ON_EXIT(1))
    dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
  ucie_ctl_tx_gen2 #(.FIFO_D_SIZE(64), .FIFO_P_SIZE(3), .AFULL_MARGIN(2),
                     .UCIE_ACTIVE(1), .DRAIN_ON_EXIT(0))
    dut_f (.i_clk(clk), .i_rst(rst), .bus(if_f));
  ucie_ctl_tx_gen2 #(.FIFO_D_SIZE(64), .FIFO_P_SIZE(3), .AFULL_MARGIN(0),
                     .UCIE_ACTIVE(1), .DRAIN_ON_EXIT(1))
    dut_o (.i_clk(clk), .i_rst(rst), .bus(if_o));

  typedef struct {
    logic        rst;
    logic [3:0]  sts;
    logic        vld;
    logic        irdy;
    logic        rtrdy;
    logic [63:0] dat;
    logic [1:0]  st;
    logic        trdy;
    logic [3:0]  lvl;
    logic        ovld;
    logic [63:0] odat;
    logic [1:0]  f_st;
    logic [3:0]  f_lvl;
    logic        f_ovld;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Inputs for one cycle plus the outputs expected during that same cycle
  // (outputs depend on registers only, i.e. on earlier vectors).
  task automatic add(input logic r, input logic [3:0] s, input logic v, input logic ir,
                     input logic rt, input logic [63:0] d, input logic [1:0] st,
                     input logic tr, input logic [3:0] lv, input logic ov,
                     input logic [63:0] od);
    vec_t e;
    e.rst = r; e.sts = s; e.vld = v; e.irdy = ir; e.rtrdy = rt; e.dat = d;
    e.st = st; e.trdy = tr; e.lvl = lv; e.ovld = ov; e.odat = od;
    e.f_st = st; e.f_lvl = lv; e.f_ovld = ov;
    vq.push_back(e);
  endtask

  // Override the flush-instance expectation of the last vector.
  task automatic setf(input logic [1:0] st, input logic [3:0] lv, input logic ov);
    vec_t e;
    e = vq.pop_back();
    e.f_st = st; e.f_lvl = lv; e.f_ovld = ov;
    vq.push_back(e);
  endtask

`ifdef UCIE_CTL_TX_PARITY_EN
  function automatic logic [7:0] par_of(input logic [63:0] d);
    logic [7:0] p;
    p = '0;
    for (int b = 0; b < 8; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction
`endif

  initial begin
    rst = 1'b0; sts = A1; vld = 1'b0; irdy = 1'b0; rtrdy = 1'b0; dat = '0;
    if_o.i_fdi_pl_state_sts = A1;
    if_o.i_fdi_lp_valid     = 1'b0;
    if_o.i_fdi_lp_irdy      = 1'b0;
    if_o.i_fdi_lp_data      = '0;
    if_o.i_rdi_pl_trdy      = 1'b0;

    // Reset and bring-up.
    add(0, A1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, A1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    // Continuous valid, PHY stalled: 6 accepted, trdy drops at level 6.
    for (int i = 1; i <= 6; i++)
      add(1, A1, 1, 1, 0, 64'(i), 2'b01, 1, 4'(i-1), (i > 1), 64'd1);
    add(1, A1, 1, 1, 0, 64'd7, 2'b01, 0, 4'd6, 1, 64'd1);
    add(1, A1, 1, 1, 1, 64'd7, 2'b01, 0, 4'd6, 1, 64'd1);
    // One pop released trdy; flit 7 goes in.
    add(1, A1, 1, 1, 0, 64'd7, 2'b01, 1, 4'd5, 1, 64'd2);
    for (int i = 0; i < 6; i++)
      add(1, A1, 0, 0, 1, 64'd0, 2'b01, (i > 0), 4'(6-i), 1, 64'(2+i));
    add(1, A1, 0, 0, 0, 64'd0, 2'b01, 1, 4'd0, 0, 64'd0);
    // Valid without irdy is not a push.
    add(1, A1, 1, 0, 0, 64'hdead, 2'b01, 1, 4'd0, 0, 64'd0);
    // Simultaneous push/pop stream of 20 flits, wrapping the pointers.
    for (int i = 0; i <= 20; i++)
      add(1, A1, (i < 20), (i < 20), 1, 64'h100 + 64'(i), 2'b01, 1,
          (i == 0) ? 4'd0 : 4'd1, (i != 0), 64'h100 + 64'(i) - 64'd1);
    add(1, A1, 0, 0, 0, 64'd0, 2'b01, 1, 4'd0, 0, 64'd0);
    // Load 4 flits, then leave Active (Retrain).
    for (int j = 0; j < 4; j++)
      add(1, A1, 1, 1, 0, 64'h201 + 64'(j), 2'b01, 1, 4'(j), (j > 0), 64'h201);
    add(1, RT, 0, 0, 0, 64'd0, 2'b01, 1, 4'd4, 1, 64'h201);
    add(1, RT, 1, 1, 1, 64'hbad, 2'b10, 0, 4'd4, 1, 64'h201);
    setf(2'b11, 4'd0, 0);
    for (int j = 1; j < 4; j++) begin
      add(1, RT, 1, 1, 1, 64'hbad, 2'b10, 0, 4'(4-j), 1, 64'h201 + 64'(j));
      setf(2'b00, 4'd0, 0);
    end
    add(1, RT, 1, 1, 1, 64'hbad, 2'b10, 0, 4'd0, 0, 64'd0);
    setf(2'b00, 4'd0, 0);
    add(1, RT, 0, 0, 0, 64'd0, 2'b00, 0, 4'd0, 0, 64'd0);
    add(1, A1, 0, 0, 0, 64'd0, 2'b00, 0, 4'd0, 0, 64'd0);
    add(1, A1, 0, 0, 0, 64'd0, 2'b01, 1, 4'd0, 0, 64'd0);

    foreach (vq[k]) begin
      @(negedge clk);
      chk($sformatf("v%0d a_state", k), 64'(if_a.o_tx_state),     64'(vq[k].st));
      chk($sformatf("v%0d a_trdy", k),  64'(if_a.o_fdi_pl_trdy),  64'(vq[k].trdy));
      chk($sformatf("v%0d a_level", k), 64'(if_a.o_tx_level),     64'(vq[k].lvl));
      chk($sformatf("v%0d a_valid", k), 64'(if_a.o_rdi_lp_valid), 64'(vq[k].ovld));
      chk($sformatf("v%0d a_irdy", k),  64'(if_a.o_rdi_lp_irdy),  64'(vq[k].ovld));
      chk($sformatf("v%0d a_err", k),   64'(if_a.o_tx_overf_err), 64'd0);
      if (vq[k].ovld)
        chk($sformatf("v%0d a_data", k), if_a.o_rdi_lp_data, vq[k].odat);
`ifdef UCIE_CTL_TX_PARITY_EN
      chk($sformatf("v%0d a_dpar", k), 64'(if_a.o_rdi_lp_dpar),
          vq[k].ovld ? 64'(par_of(vq[k].odat)) : 64'd0);
`endif
      chk($sformatf("v%0d f_state", k), 64'(if_f.o_tx_state),     64'(vq[k].f_st));
      chk($sformatf("v%0d f_level", k), 64'(if_f.o_tx_level),     64'(vq[k].f_lvl));
      chk($sformatf("v%0d f_valid", k), 64'(if_f.o_rdi_lp_valid), 64'(vq[k].f_ovld));
      rst = vq[k].rst; sts = vq[k].sts; vld = vq[k].vld; irdy = vq[k].irdy;
      rtrdy = vq[k].rtrdy; dat = vq[k].dat;
    end

    // Zero-margin instance: fill to 8, then force a write into the full FIFO.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("o_fill%0d_trdy", i), 64'(if_o.o_fdi_pl_trdy), 64'd1);
      chk($sformatf("o_fill%0d_level", i), 64'(if_o.o_tx_level), 64'(i));
      if_o.i_fdi_lp_valid = 1'b1;
      if_o.i_fdi_lp_irdy  = 1'b1;
      if_o.i_fdi_lp_data  = 64'h301 + 64'(i);
    end
    @(negedge clk);
    chk("o_full_trdy",  64'(if_o.o_fdi_pl_trdy),  64'd0);
    chk("o_full_level", 64'(if_o.o_tx_level),     64'd8);
    chk("o_full_err",   64'(if_o.o_tx_overf_err), 64'd0);
    chk("o_full_head",  if_o.o_rdi_lp_data,       64'h301);
    if_o.i_fdi_lp_data = 64'hbad;
    @(negedge clk);
    chk("o_ovf_err",   64'(if_o.o_tx_overf_err), 64'd1);
    chk("o_ovf_level", 64'(if_o.o_tx_level),     64'd8);
    if_o.i_rdi_pl_trdy = 1'b1;
    @(negedge clk);
    chk("o_ovfpop_err",   64'(if_o.o_tx_overf_err), 64'd1);
    chk("o_ovfpop_level", 64'(if_o.o_tx_level),     64'd7);
    chk("o_ovfpop_head",  if_o.o_rdi_lp_data,       64'h302);
    if_o.i_fdi_lp_valid = 1'b0;
    if_o.i_rdi_pl_trdy  = 1'b0;
    @(negedge clk);
    chk("o_sticky_err", 64'(if_o.o_tx_overf_err), 64'd1);
    chk("o_hold_level", 64'(if_o.o_tx_level),     64'd7);
    // Reset with flits stored: contents discarded, error cleared.
    rst = 1'b0;
    @(negedge clk);
    chk("o_rst_err",   64'(if_o.o_tx_overf_err), 64'd0);
    chk("o_rst_level", 64'(if_o.o_tx_level),     64'd0);
    chk("o_rst_valid", 64'(if_o.o_rdi_lp_valid), 64'd0);
    chk("o_rst_state", 64'(if_o.o_tx_state),     64'd0);
    chk("a_rst_state", 64'(if_a.o_tx_state),     64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("o_up_state", 64'(if_o.o_tx_state),     64'd1);
    chk("o_up_err",   64'(if_o.o_tx_overf_err), 64'd0);
    chk("o_up_trdy",  64'(if_o.o_fdi_pl_trdy),  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_tx_gen2.md
Name: ucie_ctl_tx_gen2

Overview:
Second-generation UCIe controller TX datapath between the FDI (adapter-facing) and RDI (PHY-facing) interfaces. It combines a parametrised single-clock first-word-fall-through FIFO with a link-state-aware control FSM. Over the first generation it adds:
- almost-full backpressure with a configurable margin;
- graceful drain on leaving Active;
- an occupancy output;
- a state output for debug.

Parameters:
- FIFO_D_SIZE, 64, flit data width in bits.
- FIFO_P_SIZE, 3, pointer width; depth = 2**FIFO_P_SIZE.
- AFULL_MARGIN, 2, free slots reserved. o_fdi_pl_trdy drops when level >= depth - AFULL_MARGIN. Legal range 0..depth-1.
- UCIE_ACTIVE, 1. 1 = gate on link state. 0 = treat the link as permanently Active.
- DRAIN_ON_EXIT, 1. 1 = drain the FIFO to RDI on leaving Active. 0 = flush immediately.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_fdi_pl_state_sts  in  4  link state; 4'b0001 = Active.
- i_fdi_lp_valid  in  1  adapter flit valid.
- i_fdi_lp_irdy  in  1  adapter ready.
- i_fdi_lp_data  in  FIFO_D_SIZE  flit data.
- o_fdi_pl_trdy  out  1  TX accepts a flit.
- i_rdi_pl_trdy  in  1  PHY accepts a flit.
- o_rdi_lp_valid  out  1  head flit valid.
- o_rdi_lp_irdy  out  1  TX ready to send.
- o_rdi_lp_data  out  FIFO_D_SIZE  head flit.
- o_tx_overf_err  out  1  sticky overflow error.
- o_tx_level  out  FIFO_P_SIZE+1  FIFO occupancy, 0..depth.
- o_tx_state  out  2  FSM state encoding.

Behaviour:
- Reset (i_rst=0 at a rising edge):
  - pointers and level cleared; FSM to IDLE.
  - all outputs 0; o_rdi_lp_data shows memory content, don't-care.
  - Reset mid-transfer discards all stored flits.
- Active condition: act = (i_fdi_pl_state_sts==4'b0001) | (UCIE_ACTIVE==0).
- FSM states and transitions:
  - IDLE (2'b00): FIFO empty, no accept, no send. Goes to ACTIVE when act.
  - ACTIVE (2'b01): accept and forward.
    - !act and DRAIN_ON_EXIT=1 and level!=0 → DRAIN.
    - !act otherwise → FLUSH.
  - DRAIN (2'b10): no accept; keep forwarding.
    - level reaches 0 → IDLE.
    - act reasserts → ACTIVE (contents preserved).
  - FLUSH (2'b11): pointers reset to equal, level=0 this cycle → IDLE next cycle.
- o_fdi_pl_trdy = (state==ACTIVE) & (level < depth-AFULL_MARGIN). Decoded from registers only; no input-to-output combinational path.
- Push: i_fdi_lp_valid & i_fdi_lp_irdy & o_fdi_pl_trdy. Data written at the edge; o_rdi_lp_valid rises the next cycle (latency 1).
- RDI outputs: o_rdi_lp_valid = o_rdi_lp_irdy = (state in {ACTIVE, DRAIN}) & (level!=0). o_rdi_lp_data = mem[rptr] (FWFT).
- Pop: o_rdi_lp_valid & i_rdi_pl_trdy.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointer wrap: wraps modulo depth. Level is computed from registered counts, never from pointer compare alone.
- Overflow:
  - Condition: i_fdi_lp_valid & i_fdi_lp_irdy & (level==depth) while state==ACTIVE. This is an adapter protocol violation.
  - Response: flit dropped, o_tx_overf_err set next cycle and held until reset. A same-cycle pop does not prevent the error.
- Valid asserted outside ACTIVE (trdy=0): ignored, not an error.
- AFULL_MARGIN=0: trdy stays high until full.

Optional Feature:
UCIE_CTL_TX_PARITY_EN.
- Defined:
  - FIFO width grows to FIFO_D_SIZE + FIFO_D_SIZE/8.
  - Even parity per byte is computed at push and stored with the data.
  - Adds output o_rdi_lp_dpar [FIFO_D_SIZE/8], valid with o_rdi_lp_valid, reset 0.
- Undefined: no parity storage and no o_rdi_lp_dpar port.

Decomposition:
- Package ucie_ctl_pkg holds:
  - state typedef tx_state_t {IDLE, ACTIVE, DRAIN, FLUSH};
  - constant LSTS_ACTIVE = 4'b0001.
- One sub-module, ucie_ctl_tx_sync_fifo: parametrised width/depth FWFT FIFO with level counter, push/pop/flush inputs and full/empty outputs.
- The FSM and handshake glue live in the top.

Test Plan:
- Reset and bring-up: reset, then state_sts=0001 → o_tx_state 00 then 01 on the next cycle; trdy=1; level=0; all RDI outputs 0.
- Streaming with defaults: depth 8, margin 2, continuous adapter valid, i_rdi_pl_trdy=0 →
  - 6 flits accepted;
  - trdy drops when level=6;
  - trdy releases after one pop;
  - data appears in order 0x1..0x6.
- Simultaneous push/pop with i_rdi_pl_trdy=1 and a continuous stream → level stays 1; 20 flits pass in order, including pointer wrap.
- Drain path: DRAIN_ON_EXIT=1, level=4, state_sts→1011 (Retrain) →
  - state=DRAIN, trdy=0;
  - 4 flits emitted;
  - then IDLE.
- Flush path: DRAIN_ON_EXIT=0 under the same stimulus → FLUSH for one cycle, level=0, no flits emitted.
- Overflow: AFULL_MARGIN=0, fill to 8, adapter forces valid&irdy → o_tx_overf_err=1 the next cycle and remains 1; cleared only by reset.
- Parity build with UCIE_CTL_TX_PARITY_EN: push 0x01 in byte 0 → o_rdi_lp_dpar[0]=1, all other bits 0.
